// File: rtl/id_exe_reg_if.sv
// ID -> EXE bundle: forwarded operands and control in, latched copies out.
// The register itself sits on the slave side.
interface id_exe_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_reg1_data;
    logic [DATA_W-1:0] id_reg2_data;
    logic [DATA_W-1:0] id_sw_data;
    logic [ADDR_W-1:0] id_write_addr;
    logic              id_reg_write;
    logic              id_DM_read;
    logic              id_DM_write;
    logic              id_movsrc;
    logic [DATA_W-1:0] id_mov_data;
    logic [CTRL_W-1:0] id_ctrl;

    logic              exe_valid;
    logic [DATA_W-1:0] exe_reg1;
    logic [DATA_W-1:0] exe_reg2;
    logic [DATA_W-1:0] exe_sw;
    logic [ADDR_W-1:0] exe_write_addr;
    logic              exe_reg_write;
    logic              exe_DM_read;
    logic              exe_DM_write;
    logic              exe_movsrc;
    logic [DATA_W-1:0] exe_mov_data;
    logic [CTRL_W-1:0] exe_ctrl;

    modport master (
        output id_valid, id_reg1_data, id_reg2_data, id_sw_data,
        output id_write_addr, id_reg_write, id_DM_read, id_DM_write,
        output id_movsrc, id_mov_data, id_ctrl,
        input  exe_valid, exe_reg1, exe_reg2, exe_sw,
        input  exe_write_addr, exe_reg_write, exe_DM_read, exe_DM_write,
        input  exe_movsrc, exe_mov_data, exe_ctrl
    );

    modport slave (
        input  id_valid, id_reg1_data, id_reg2_data, id_sw_data,
        input  id_write_addr, id_reg_write, id_DM_read, id_DM_write,
        input  id_movsrc, id_mov_data, id_ctrl,
        output exe_valid, exe_reg1, exe_reg2, exe_sw,
        output exe_write_addr, exe_reg_write, exe_DM_read, exe_DM_write,
        output exe_movsrc, exe_mov_data, exe_ctrl
    );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with the load/jump stall sequencer.
// A stalled instruction issues once, then LOAD_BUBBLES bubbles follow.
module id_exe_reg #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int CTRL_W       = 16,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall_req,
    input  logic        exe_hold,
    input  logic        flush,
    id_exe_reg_if.slave bus,
    output logic        stall_release
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUBBLE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] sw;
        logic [ADDR_W-1:0] waddr;
        logic              reg_write;
        logic              dm_read;
        logic              dm_write;
        logic              movsrc;
        logic [DATA_W-1:0] mov;
        logic [CTRL_W-1:0] ctrl;
    } exe_t;

    localparam logic [2:0] LB_CNT = 3'(LOAD_BUBBLES);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       capture;
    logic       bubble;
    exe_t       exe_q;
    exe_t       id_pkt;

    assign id_pkt = '{
        valid:     1'b1,
        reg1:      bus.id_reg1_data,
        reg2:      bus.id_reg2_data,
        sw:        bus.id_sw_data,
        waddr:     bus.id_write_addr,
        reg_write: bus.id_reg_write,
        dm_read:   bus.id_DM_read,
        dm_write:  bus.id_DM_write,
        movsrc:    bus.id_movsrc,
        mov:       bus.id_mov_data,
        ctrl:      bus.id_ctrl
    };

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        bubble        = 1'b0;
        stall_release = 1'b0;
        if (exe_hold) begin
            state_d = state_q;
        end else if (flush) begin
            bubble  = 1'b1;
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.id_valid && id_stall_req) begin
                        capture = 1'b1;
                        state_d = ISSUE;
                        cnt_d   = LB_CNT;
                    end else if (bus.id_valid) begin
                        capture = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                ISSUE, BUBBLE: begin
                    // stalled instr still sits in ID; never take it twice
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        stall_release = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = BUBBLE;
                    end
                end
                default: begin
                    bubble  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            exe_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                exe_q <= id_pkt;
            end else if (bubble) begin
                exe_q <= '0;
            end
        end
    end

    assign bus.exe_valid      = exe_q.valid;
    assign bus.exe_reg1       = exe_q.reg1;
    assign bus.exe_reg2       = exe_q.reg2;
    assign bus.exe_sw         = exe_q.sw;
    assign bus.exe_write_addr = exe_q.waddr;
    assign bus.exe_reg_write  = exe_q.reg_write;
    assign bus.exe_DM_read    = exe_q.dm_read;
    assign bus.exe_DM_write   = exe_q.dm_write;
    assign bus.exe_movsrc     = exe_q.movsrc;
    assign bus.exe_mov_data   = exe_q.mov;
    assign bus.exe_ctrl       = exe_q.ctrl;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: two instances (1 and 3 bubbles) share one ID stream
// and are compared every cycle against an instruction-level model.
module tb_id_exe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        stall, hold, flush;
    logic        id_valid;
    logic [31:0] r1, r2, sw, mov;
    logic [4:0]  wa;
    logic        rw, dmr, dmw, ms;
    logic [15:0] ctrl;
    logic        rel1, rel3;

    int n_cmp = 0;
    int n_bad = 0;

    id_exe_reg_if b1 ();
    id_exe_reg_if b3 ();

    assign b1.id_valid      = id_valid;
    assign b1.id_reg1_data  = r1;
    assign b1.id_reg2_data  = r2;
    assign b1.id_sw_data    = sw;
    assign b1.id_write_addr = wa;
    assign b1.id_reg_write  = rw;
    assign b1.id_DM_read    = dmr;
    assign b1.id_DM_write   = dmw;
    assign b1.id_movsrc     = ms;
    assign b1.id_mov_data   = mov;
    assign b1.id_ctrl       = ctrl;

    assign b3.id_valid      = id_valid;
    assign b3.id_reg1_data  = r1;
    assign b3.id_reg2_data  = r2;
    assign b3.id_sw_data    = sw;
    assign b3.id_write_addr = wa;
    assign b3.id_reg_write  = rw;
    assign b3.id_DM_read    = dmr;
    assign b3.id_DM_write   = dmw;
    assign b3.id_movsrc     = ms;
    assign b3.id_mov_data   = mov;
    assign b3.id_ctrl       = ctrl;

    id_exe_reg #(.LOAD_BUBBLES(1)) u1 (
        .clk(clk), .rst(rst), .id_stall_req(stall), .exe_hold(hold),
        .flush(flush), .bus(b1), .stall_release(rel1)
    );

    id_exe_reg #(.LOAD_BUBBLES(3)) u3 (
        .clk(clk), .rst(rst), .id_stall_req(stall), .exe_hold(hold),
        .flush(flush), .bus(b3), .stall_release(rel3)
    );

    wire [153:0] act1 = {b1.exe_valid, b1.exe_reg1, b1.exe_reg2, b1.exe_sw,
                         b1.exe_write_addr, b1.exe_reg_write, b1.exe_DM_read,
                         b1.exe_DM_write, b1.exe_movsrc, b1.exe_mov_data, b1.exe_ctrl};
    wire [153:0] act3 = {b3.exe_valid, b3.exe_reg1, b3.exe_reg2, b3.exe_sw,
                         b3.exe_write_addr, b3.exe_reg_write, b3.exe_DM_read,
                         b3.exe_DM_write, b3.exe_movsrc, b3.exe_mov_data, b3.exe_ctrl};
    wire [153:0] cap  = {1'b1, r1, r2, sw, wa, rw, dmr, dmw, ms, mov, ctrl};

    // model: what EXE must hold, and how many bubbles are still owed
    logic [153:0] exp_q [2];
    int           rem   [2];
    int           lbv   [2] = '{1, 3};

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                exp_q[k] = '0;
                rem[k]   = 0;
            end else if (hold) begin
                rem[k] = rem[k];
            end else if (flush) begin
                exp_q[k] = '0;
                rem[k]   = 0;
            end else if (rem[k] > 0) begin
                exp_q[k] = '0;
                rem[k]   = rem[k] - 1;
            end else if (id_valid) begin
                exp_q[k] = cap;
                rem[k]   = stall ? lbv[k] : 0;
            end else begin
                exp_q[k] = '0;
            end
        end
    end

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("exe1", 160'(act1), 160'(exp_q[0]));
        chk("exe3", 160'(act3), 160'(exp_q[1]));
        chk("rel1", 160'(rel1), 160'(rst && !hold && !flush && rem[0] == 1));
        chk("rel3", 160'(rel3), 160'(rst && !hold && !flush && rem[1] == 1));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        id_valid = 1'b0; stall = 1'b0; hold = 1'b0; flush = 1'b0;
        rw = 1'b0; dmr = 1'b0; dmw = 1'b0; ms = 1'b0;
    endtask

    task automatic rand_data();
        r1 = $urandom; r2 = $urandom; sw = $urandom; mov = $urandom;
        wa = 5'($urandom); ctrl = 16'($urandom);
        rw = 1'($urandom); ms = 1'($urandom);
        dmr = 1'($urandom); dmw = 1'($urandom);
    endtask

    task automatic rand_all();
        rand_data();
        id_valid = ($urandom_range(0, 3) != 0);
        stall    = ($urandom_range(0, 3) == 0);
        hold     = ($urandom_range(0, 9) == 0);
        flush    = ($urandom_range(0, 11) == 0);
    endtask

    task automatic load_lw();
        quiet();
        rand_data();
        id_valid = 1'b1; stall = 1'b1; dmr = 1'b1; dmw = 1'b0; rw = 1'b1;
    endtask

    task automatic next_instr(input logic [31:0] v);
        rand_data();
        id_valid = 1'b1; stall = 1'b0; dmr = 1'b0; dmw = 1'b0;
        hold = 1'b0; flush = 1'b0; r1 = v;
    endtask

    initial begin
        rand_all();
        #2;
        chk("rst_exe1", 160'(act1), 160'd0);
        chk("rst_rel1", 160'(rel1), 160'd0);
        step(); step();
        rst = 1'b1;

        // plain flow
        quiet(); rand_data();
        id_valid = 1'b1; r1 = 32'h1234_5678; wa = 5'd3; rw = 1'b1;
        step();
        chk("flow_reg1", 160'(b1.exe_reg1), 160'h1234_5678);
        chk("flow_wa", 160'(b1.exe_write_addr), 160'd3);
        chk("flow_valid", 160'(b1.exe_valid), 160'd1);

        // LW stall, one bubble
        quiet(); step(); step(); step(); step();
        load_lw();
        step();
        chk("lw1_read", 160'(b1.exe_DM_read), 160'd1);
        chk("lw1_valid", 160'(b1.exe_valid), 160'd1);
        chk("lw1_rel", 160'(rel1), 160'd1);
        step();
        chk("lw1_bub", 160'(b1.exe_valid), 160'd0);
        chk("lw1_rel0", 160'(rel1), 160'd0);
        next_instr(32'hCAFE_0001);
        step();
        chk("lw1_next", 160'(b1.exe_reg1), 160'hCAFE_0001);
        chk("lw1_once", 160'(b1.exe_DM_read), 160'd0);

        // LW stall, three bubbles
        quiet(); step(); step(); step(); step();
        load_lw();
        step();
        chk("lw3_read", 160'(b3.exe_DM_read), 160'd1);
        chk("lw3_rel_a", 160'(rel3), 160'd0);
        step();
        chk("lw3_bub1", 160'(b3.exe_valid), 160'd0);
        chk("lw3_rel_b", 160'(rel3), 160'd0);
        step();
        chk("lw3_bub2", 160'(b3.exe_valid), 160'd0);
        chk("lw3_rel_c", 160'(rel3), 160'd1);
        step();
        chk("lw3_bub3", 160'(b3.exe_valid), 160'd0);
        chk("lw3_rel_d", 160'(rel3), 160'd0);
        next_instr(32'hBEEF_0002);
        step();
        chk("lw3_next", 160'(b3.exe_reg1), 160'hBEEF_0002);
        chk("lw3_nvalid", 160'(b3.exe_valid), 160'd1);

        // hold while two bubbles remain
        quiet(); step(); step(); step(); step();
        load_lw();
        step(); step();
        hold = 1'b1;
        step();
        chk("hold_rel_a", 160'(rel3), 160'd0);
        chk("hold_valid", 160'(b3.exe_valid), 160'd0);
        step();
        chk("hold_rel_b", 160'(rel3), 160'd0);
        hold = 1'b0;
        step();
        chk("hold_resume", 160'(rel3), 160'd1);
        step();

        // flush of a store, then flush mid-bubble
        quiet(); step(); step(); step();
        rand_data();
        id_valid = 1'b1; dmw = 1'b1; flush = 1'b1;
        step();
        chk("fl_store", 160'(b1.exe_DM_write), 160'd0);
        chk("fl_valid", 160'(b1.exe_valid), 160'd0);
        load_lw();
        step();
        flush = 1'b1;
        #1;
        chk("fl_gate_rel", 160'(rel1), 160'd0);
        step();
        chk("fl_bub_valid", 160'(b3.exe_valid), 160'd0);
        quiet();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_rel", 160'(rel3), 160'd0);
        end

        // random traffic with an async reset mid-run
        for (int i = 0; i < 3000; i++) begin
            rand_all();
            step();
            if (i == 1500) begin
                #3 rst = 1'b0;
                #1;
                chk("mid_rst1", 160'(act1), 160'd0);
                chk("mid_rst3", 160'(act3), 160'd0);
                chk("mid_rel", 160'({rel1, rel3}), 160'd0);
                step(); step();
                rst = 1'b1;
            end
        end

        quiet();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
